weight_bias_fetch: RTL

- Streaming weight/bias fetch unit that sits directly downstream of the master control path and upstream of the CORDIC MAC datapath.
- On each weight-load request from the master (`weight_en` rising), it reads one neuron's bias and `fan_in` weights from synchronous weight/bias ROMs.
- It presents them to the MAC as a valid-qualified stream.
- Address pointers advance sequentially across neurons and layers, so no per-layer base table is needed.

---
 rtl/weight_bias_fetch.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/weight_bias_fetch.sv
// Weight/bias fetch unit: per request, reads one bias and fan_in weights from
// synchronous ROMs and streams them to the MAC. Optional WBF_BOUND_CHECK_EN adds oob.
module weight_bias_fetch #(
  parameter int DW      = 16,
  parameter int WAW     = 14,
  parameter int BAW     = 8,
  parameter int RD_LAT  = 1
`ifdef WBF_BOUND_CHECK_EN
  ,
  parameter int W_DEPTH = 2**WAW,
  parameter int B_DEPTH = 2**BAW
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           weight_en,
  input  logic [9:0]     fan_in,
  output logic           w_rd_en,
  output logic [WAW-1:0] w_addr,
  input  logic [DW-1:0]  w_rdata,
  output logic           b_rd_en,
  output logic [BAW-1:0] b_addr,
  input  logic [DW-1:0]  b_rdata,
  output logic [DW-1:0]  w_out,
  output logic           w_valid,
  output logic           w_last,
  output logic [DW-1:0]  b_out,
  output logic           b_valid,
  output logic           busy,
  output logic           done,
  output logic           overrun
`ifdef WBF_BOUND_CHECK_EN
  ,
  output logic           oob
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [9:0]     cnt, cnt_nxt;
  logic [1:0]     drain_cnt, drain_nxt;
  logic [WAW-1:0] w_ptr;
  logic [BAW-1:0] b_ptr;
  logic           weight_en_q;
  logic           req;
  logic           b_first;
  logic           last_issue;
  logic           vld_p1, vld_p2, last_p1, last_p2, bvld_p1, bvld_p2;
  logic [DW-1:0]  b_hold;

  assign req    = weight_en & ~weight_en_q;
  assign w_addr = w_ptr;
  assign b_addr = b_ptr;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    drain_nxt  = drain_cnt;
    w_rd_en    = 1'b0;
    b_rd_en    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    last_issue = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt   = fan_in;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        busy    = 1'b1;
        b_rd_en = b_first;
        if (cnt != 10'd0) begin
          w_rd_en    = 1'b1;
          last_issue = (cnt == 10'd1);
          cnt_nxt    = cnt - 10'd1;
        end
        // fan_in of 0 falls through after the bias read alone
        if (cnt <= 10'd1) begin
          state_nxt = DRAIN;
          drain_nxt = 2'(RD_LAT - 1);
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 2'd0) state_nxt = DONE;
        else                   drain_nxt = drain_cnt - 2'd1;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      drain_cnt   <= '0;
      w_ptr       <= '0;
      b_ptr       <= '0;
      weight_en_q <= 1'b0;
      b_first     <= 1'b0;
      overrun     <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      last_p1     <= 1'b0;
      last_p2     <= 1'b0;
      bvld_p1     <= 1'b0;
      bvld_p2     <= 1'b0;
      b_hold      <= '0;
    end else if (start) begin
      state       <= IDLE;
      w_ptr       <= '0;
      b_ptr       <= '0;
      weight_en_q <= weight_en;
      b_first     <= 1'b0;
      overrun     <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      last_p1     <= 1'b0;
      last_p2     <= 1'b0;
      bvld_p1     <= 1'b0;
      bvld_p2     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      drain_cnt   <= drain_nxt;
      weight_en_q <= weight_en;
      b_first     <= (state == IDLE) && req;
      if (w_rd_en) w_ptr <= w_ptr + 1'b1;
      if (done)    b_ptr <= b_ptr + 1'b1;
      if (req && (state != IDLE)) overrun <= 1'b1;
      // stage 1/2: read-latency valid pipeline
      vld_p1  <= w_rd_en;
      vld_p2  <= vld_p1;
      last_p1 <= last_issue;
      last_p2 <= last_p1;
      bvld_p1 <= b_rd_en;
      bvld_p2 <= bvld_p1;
      if (b_valid) b_hold <= b_rdata;
    end
  end

  // output stage: ROM data passes straight through on the matching valid beat
  assign w_valid = (RD_LAT == 1) ? vld_p1  : vld_p2;
  assign w_last  = (RD_LAT == 1) ? last_p1 : last_p2;
  assign b_valid = (RD_LAT == 1) ? bvld_p1 : bvld_p2;
  assign w_out   = w_valid ? w_rdata : '0;
  assign b_out   = b_valid ? b_rdata : b_hold;

`ifdef WBF_BOUND_CHECK_EN
  logic oob_q, oob_hit;
  assign oob_hit = (w_rd_en && (32'(w_ptr) >= $unsigned(W_DEPTH))) ||
                   (b_rd_en && (32'(b_ptr) >= $unsigned(B_DEPTH)));
  assign oob     = oob_q | oob_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       oob_q <= 1'b0;
    else if (start)   oob_q <= 1'b0;
    else if (oob_hit) oob_q <= 1'b1;
  end
`endif

endmodule
